// File: rtl/even_parity_pkg.sv
// Shared definitions for the even-parity checker slice: default widths and
// the parity check function used by the top level.
package even_parity_pkg;

  localparam int DATA_W_DEF = 3;
  localparam int CNT_W_DEF  = 8;

  // Widest data word the checker supports; narrower words are zero-extended
  // before the check, which leaves their parity unchanged.
  localparam int DATA_W_MAX = 64;

  // Returns 1 when the total number of ones across data and p is odd,
  // i.e. the word violates even parity.
  function automatic logic parity_err(input logic [DATA_W_MAX-1:0] data,
                                      input logic                  p);
    return (^data) ^ p;
  endfunction

endpackage : even_parity_pkg

// File: rtl/epc_sat_counter.sv
// Saturating event counter with synchronous clear. An increment that lands
// on the same edge as a clear loads one, so the event is never lost.
module epc_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE  = W'(1'b1);
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_next_s;

  // Next-count selection: clear, increment with saturation, or hold.
  always_comb begin
    cnt_next_s = cnt_r;
    if (inc) begin
      if (clr) begin
        cnt_next_s = CNT_ONE;
      end else if (cnt_r == CNT_MAX) begin
        cnt_next_s = cnt_r;
      end else begin
        cnt_next_s = cnt_r + CNT_ONE;
      end
    end else if (clr) begin
      cnt_next_s = CNT_ZERO;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign cnt = cnt_r;

endmodule : epc_sat_counter

// File: rtl/even_parity_checker.sv
// Registered even-parity checker: one DATA_W-bit word plus its received
// parity bit per valid cycle, result one cycle later, with a sticky error
// flag. The saturating error counter is built only when the macro
// EVEN_PARITY_CHECKER_ERR_CNT_EN is defined; otherwise err_cnt reads zero.
module even_parity_checker
  import even_parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data,
  input  logic              p,
  input  logic              clr,
  output logic              pc_valid,
  output logic              pc,
  output logic              sticky_err,
  output logic [CNT_W-1:0]  err_cnt
);

  logic             pc_next_s;
  logic             err_hit_s;
  logic             pc_valid_r;
  logic             pc_r;
  logic             sticky_err_r;
  logic [CNT_W-1:0] err_cnt_s;

  // Parity check of the incoming word; an error only counts when qualified
  // by in_valid, so unknown data on idle cycles cannot reach any state.
  always_comb begin
    pc_next_s = parity_err(DATA_W_MAX'(data), p);
    err_hit_s = in_valid & pc_next_s;
  end

  // Result register: valid follows in_valid, pc holds on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_valid_r <= 1'b0;
      pc_r       <= 1'b0;
    end else begin
      pc_valid_r <= in_valid;
      if (in_valid) begin
        pc_r <= pc_next_s;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  // Sticky error flag; a captured error takes priority over clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_err_r <= 1'b0;
    end else if (err_hit_s) begin
      sticky_err_r <= 1'b1;
    end else if (clr) begin
      sticky_err_r <= 1'b0;
    end else begin
      sticky_err_r <= sticky_err_r;
    end
  end

`ifdef EVEN_PARITY_CHECKER_ERR_CNT_EN
  epc_sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (err_hit_s),
    .cnt (err_cnt_s)
  );
`else
  assign err_cnt_s = {CNT_W{1'b0}};
`endif

  assign pc_valid   = pc_valid_r;
  assign pc         = pc_r;
  assign sticky_err = sticky_err_r;
  assign err_cnt    = err_cnt_s;

endmodule : even_parity_checker

// File: tb/tb_even_parity_checker.sv
// Self-checking bench for even_parity_checker (DATA_W=3, CNT_W=8): directed
// sweep, sticky/clear cases, idle gaps, random traffic, counter saturation
// and asynchronous reset, all against a behavioural reference model.
module tb_even_parity_checker;

  localparam int DATA_W  = 3;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] data;
  logic              p;
  logic              clr;
  logic              pc_valid;
  logic              pc;
  logic              sticky_err;
  logic [CNT_W-1:0]  err_cnt;

  int total_cnt;
  int bad_cnt;

  // Reference model state
  logic m_pc_valid;
  logic m_pc;
  logic m_sticky;
  int   m_cnt;

  even_parity_checker #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .data       (data),
    .p          (p),
    .clr        (clr),
    .pc_valid   (pc_valid),
    .pc         (pc),
    .sticky_err (sticky_err),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_cnt();
`ifdef EVEN_PARITY_CHECKER_ERR_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic check_all(input string tag);
    check_val({tag, ".pc_valid"}, 64'(pc_valid), 64'(m_pc_valid));
    check_val({tag, ".pc"}, 64'(pc), 64'(m_pc));
    check_val({tag, ".sticky"}, 64'(sticky_err), 64'(m_sticky));
    check_val({tag, ".err_cnt"}, 64'(err_cnt), 64'(exp_cnt()));
  endtask

  task automatic model_reset();
    m_pc_valid = 1'b0;
    m_pc       = 1'b0;
    m_sticky   = 1'b0;
    m_cnt      = 0;
  endtask

  // Drive one cycle, advance the model by the rules of the checker, compare.
  task automatic step(input string tag, input logic v, input logic [DATA_W-1:0] d,
                      input logic pb, input logic c);
    logic err;
    int   ones;
    in_valid = v;
    data     = d;
    p        = pb;
    clr      = c;
    @(posedge clk);
    #1;
    err = 1'b0;
    if (v) begin
      ones = $countones(d) + int'(pb);
      err  = (ones % 2) == 1;
      m_pc = err;
    end
    m_pc_valid = v;
    if (err) m_sticky = 1'b1;
    else if (c) m_sticky = 1'b0;
    if (err) m_cnt = c ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
    else if (c) m_cnt = 0;
    check_all(tag);
  endtask

  logic [DATA_W-1:0] sweep_d [8];
  logic              sweep_p [8];
  logic              sweep_pc[8];

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    sweep_d  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    sweep_p  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    sweep_pc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    rst      = 1'b1;
    in_valid = 1'b0;
    data     = 3'b000;
    p        = 1'b0;
    clr      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Exhaustive sweep with the fixed expected results
    for (int i = 0; i < 8; i++) begin
      step("sweep", 1'b1, sweep_d[i], sweep_p[i], 1'b0);
      check_val("sweep_pc_table", 64'(pc), 64'(sweep_pc[i]));
      if (i >= 1) check_val("sweep_sticky", 64'(sticky_err), 64'd1);
    end
`ifdef EVEN_PARITY_CHECKER_ERR_CNT_EN
    check_val("sweep_cnt4", 64'(err_cnt), 64'd4);
`endif

    // Clear pulse on an idle cycle
    step("clr_pulse", 1'b0, 3'b000, 1'b0, 1'b1);
    check_val("clr_sticky0", 64'(sticky_err), 64'd0);

    // Clear coinciding with an error word
    step("pre_err", 1'b1, 3'b001, 1'b0, 1'b0);
    step("clr_and_err", 1'b1, 3'b111, 1'b0, 1'b1);
    check_val("clr_err_sticky", 64'(sticky_err), 64'd1);
`ifdef EVEN_PARITY_CHECKER_ERR_CNT_EN
    check_val("clr_err_cnt1", 64'(err_cnt), 64'd1);
`endif

    // Idle gaps with unknown data and parity
    for (int i = 0; i < 4; i++) begin
      step("idle_x", 1'b0, 3'bxxx, 1'bx, 1'b0);
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), DATA_W'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    // Saturation: many error words back to back
    step("sat_clr", 1'b0, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < CNT_MAX + 20; i++) begin
      step("sat", 1'b1, 3'b001, 1'b0, 1'b0);
    end
`ifdef EVEN_PARITY_CHECKER_ERR_CNT_EN
    check_val("sat_max", 64'(err_cnt), 64'(CNT_MAX));
`endif

    // Asynchronous reset between edges
    step("pre_rst", 1'b1, 3'b011, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1'b1, 3'b110, 1'b1, 1'b0);
    check_val("post_rst_pc", 64'(pc), 64'd1);
    step("post_rst2", 1'b1, 3'b101, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule : tb_even_parity_checker
